quotient_bcd: RTL and testbench
===============================

QUOTIENT_BCD -- requirements
Module: quotient_bcd

Interface
REQ-001 SHALL have parameter Q_WIDTH, default 27: width of the divider quotient.
REQ-002 SHALL have parameter DIGITS, default 9: BCD digits out; must cover 2^Q_WIDTH-1.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_quotient, input, Q_WIDTH: quotient from the divider (o_quotient_out).
REQ-006 SHALL have port i_complete, input, 1: divider completion flag (o_complete); level may persist for several cycles.
REQ-007 SHALL have port i_overflow, input, 1: divider overflow flag (o_overflow).
REQ-008 SHALL have port o_bcd, output, 4*DIGITS: packed BCD result, digit 0 in bits [3:0].
REQ-009 SHALL have port o_valid, output, 1: one-cycle pulse, o_bcd/o_overflow freshly updated.
REQ-010 SHALL have port o_busy, output, 1: conversion in progress; new results ignored.
REQ-011 SHALL have port o_overflow, output, 1: registered overflow of the last accepted result.

Function
REQ-012 SHALL register i_complete each cycle and detect its rising edge (current 1, previous 0); only a rising edge starts a job.
REQ-013 SHALL implement states IDLE, SHIFT, DONE; IDLE->SHIFT on rising edge with i_overflow=0; IDLE->DONE on rising edge with i_overflow=1; SHIFT->DONE after Q_WIDTH shifts; DONE->IDLE unconditionally.
REQ-014 SHALL capture i_quotient and i_overflow into internal registers on the accepting edge (edge k).
REQ-015 SHALL in SHIFT perform one double-dabble step per cycle: add 3 to every working digit >= 5, then shift {digits, binary} left by one.
REQ-016 SHALL count shifts with a counter cleared on acceptance; SHIFT occupies edges k+1..k+Q_WIDTH.
REQ-017 SHALL in DONE load o_bcd and o_overflow and assert o_valid for exactly one cycle: edge k+Q_WIDTH+1 (normal), edge k+1 (overflow).
REQ-018 SHALL on overflow bypass conversion and load o_bcd with every digit 4'hE.
REQ-019 SHALL assert o_busy in every cycle the state is SHIFT or DONE; low in IDLE.
REQ-020 SHALL ignore rising edges of i_complete while o_busy=1; no queuing, no effect on the running job.
REQ-021 SHALL accept a new rising edge at the first edge where the state is IDLE (earliest k+Q_WIDTH+2).
REQ-022 SHALL hold o_bcd and o_overflow stable between o_valid pulses.
REQ-023 SHALL produce o_bcd=0 for i_quotient=0 and correct digits up to 2^Q_WIDTH-1 without truncation.

Reset
REQ-024 SHALL on i_rst=1 at a clock edge force state IDLE, o_bcd=0, o_valid=0, o_busy=0, o_overflow=0, shift counter 0, registered i_complete=0.
REQ-025 SHALL abort any conversion in progress on reset, no o_valid pulse; reset has priority over all inputs in the same cycle.
REQ-026 SHALL, when i_complete is already high as reset releases, treat it as a rising edge on the first non-reset edge.

Configuration
REQ-027 SHALL honour macro QUOTIENT_BCD_BLANK_EN: when defined, leading zero digits are replaced by 4'hF on load in DONE, digit 0 never blanked, overflow pattern unchanged.
REQ-028 SHALL without QUOTIENT_BCD_BLANK_EN output leading zeros as 4'h0.

Verification
REQ-029 SHALL verify: i_quotient=3, i_complete rise at edge k -> o_valid at k+28, o_bcd=36'h000000003 (blank build 36'hFFFFFFFF3), o_overflow=0.
REQ-030 SHALL verify: i_quotient=27'h7FFFFFF -> o_bcd=36'h134217727, o_valid once.
REQ-031 SHALL verify: i_overflow=1 with completion rise at edge k -> o_valid at k+1, o_bcd=36'hEEEEEEEEE, o_overflow=1.
REQ-032 SHALL verify: i_complete held high 5 cycles, plus second rise at k+10 with i_quotient=5 -> exactly one o_valid, result of first capture.
REQ-033 SHALL verify: i_rst pulsed at shift 10 of a job -> all outputs 0, no o_valid; next job i_quotient=0 -> o_bcd=36'h000000000 (blank build 36'hFFFFFFFF0).

Source files
------------

// File: rtl/quotient_bcd.sv
// Binary quotient to packed BCD converter (double dabble, one step per clock).
// Define QUOTIENT_BCD_BLANK_EN to show leading zero digits as 4'hF.
module quotient_bcd #(
  parameter int Q_WIDTH = 27,
  parameter int DIGITS  = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [Q_WIDTH-1:0]    i_quotient,
  input  logic                  i_complete,
  input  logic                  i_overflow,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam int CW = $clog2(Q_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(Q_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic                 comp_q;
  logic                 rise;
  logic                 ovf_r;
  logic [CW-1:0]        cnt;
  logic [Q_WIDTH-1:0]   bin_r;
  logic [4*DIGITS-1:0]  dig_r;
  logic [4*DIGITS-1:0]  dig_adj;
  logic [4*DIGITS-1:0]  dig_out;

  assign rise = i_complete & ~comp_q;

  // add-3 correction of every working digit before the shift
  always_comb begin
    dig_adj = dig_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_r[4*i +: 4] >= 4'd5)
        dig_adj[4*i +: 4] = dig_r[4*i +: 4] + 4'd3;
    end
  end

  // final digit presentation (optional leading-zero blanking)
`ifdef QUOTIENT_BCD_BLANK_EN
  always_comb begin
    logic lead;
    lead    = 1'b1;
    dig_out = dig_r;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && dig_r[4*i +: 4] == 4'd0)
        dig_out[4*i +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  end
`else
  always_comb begin
    dig_out = dig_r;
  end
`endif

  // control FSM, shift datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      comp_q     <= 1'b0;
      ovf_r      <= 1'b0;
      cnt        <= '0;
      bin_r      <= '0;
      dig_r      <= '0;
      o_bcd      <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      comp_q  <= i_complete;
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            bin_r  <= i_quotient;
            ovf_r  <= i_overflow;
            dig_r  <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= i_overflow ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          {dig_r, bin_r} <= {dig_adj, bin_r} << 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          o_valid    <= 1'b1;
          o_overflow <= ovf_r;
          o_bcd      <= ovf_r ? {DIGITS{4'hE}} : dig_out;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quotient_bcd.sv
// Scoreboard bench for quotient_bcd against a decimal reference model.
// Honours QUOTIENT_BCD_BLANK_EN the same way as the design.
module tb_quotient_bcd;

  localparam int QW = 27;
  localparam int ND = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [QW-1:0] quot;
  logic          cmp;
  logic          ovf;
  logic [4*ND-1:0] o_bcd;
  logic          o_valid;
  logic          o_busy;
  logic          o_overflow;

  always #5 clk = ~clk;

  quotient_bcd #(.Q_WIDTH(QW), .DIGITS(ND)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_quotient (quot),
    .i_complete (cmp),
    .i_overflow (ovf),
    .o_bcd      (o_bcd),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  typedef struct {
    logic [4*ND-1:0] bcd;
    logic            ov;
    int              at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   armed = 0;
  int   free_at = 0;
  int   acc_k = 0;
  bit   prev_c = 0;
  logic [4*ND-1:0] last_bcd = '0;
  logic            last_ovf = 1'b0;

  function automatic logic [4*ND-1:0] model(int unsigned q, bit ov);
    logic [4*ND-1:0] r;
    int unsigned v;
    r = '0;
    v = q;
    if (ov) return {ND{4'hE}};
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef QUOTIENT_BCD_BLANK_EN
    begin
      bit lead;
      lead = 1'b1;
      for (int i = ND - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed    = 1'b1;
      last_bcd = '0;
      last_ovf = 1'b0;
    end
  end

  // monitor: checks busy window, pops expected results on o_valid
  always @(negedge clk) begin
    exp_t e;
    bit   bz;
    if (armed) begin
      bz = (cyc >= acc_k) && (cyc <= free_at - 2);
      chk("busy", 64'(o_busy), 64'(bz));
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid got bcd %h want none", o_bcd);
          last_bcd = o_bcd;
          last_ovf = o_overflow;
        end else begin
          e = sb.pop_front();
          chk("bcd", 64'(o_bcd), 64'(e.bcd));
          chk("ovf", 64'(o_overflow), 64'(e.ov));
          chk("latency", 64'(cyc), 64'(e.at));
          last_bcd = e.bcd;
          last_ovf = e.ov;
        end
      end else begin
        chk("hold", 64'({o_overflow, o_bcd}), 64'({last_ovf, last_bcd}));
      end
    end
  end

  task automatic drive(bit r, bit c, logic [QW-1:0] q, bit ov);
    int e;
    @(negedge clk);
    rst  = r;
    cmp  = c;
    quot = q;
    ovf  = ov;
    e    = cyc + 1;
    if (r) begin
      if (free_at > e + 1) free_at = e + 1;
      prev_c = 1'b0;
      sb.delete();
    end else begin
      if (c && !prev_c && e >= free_at) begin
        acc_k   = e;
        free_at = e + (ov ? 2 : QW + 2);
        sb.push_back('{model(q, ov), ov, e + (ov ? 1 : QW + 1)});
      end
      prev_c = c;
    end
  endtask

  task automatic job(logic [QW-1:0] q, bit ov, int hold, int gap);
    drive(1'b0, 1'b1, q, ov);
    repeat (hold - 1) drive(1'b0, 1'b1, QW'($urandom), 1'($urandom));
    repeat (gap) drive(1'b0, 1'b0, QW'($urandom), 1'($urandom));
  endtask

  task automatic chk_zero(string tag);
    @(posedge clk);
    #1;
    chk({tag, "_bcd"}, 64'(o_bcd), 64'd0);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_ovf"}, 64'(o_overflow), 64'd0);
  endtask

  initial begin
    logic [QW-1:0] rq;
    rst  = 1'b1;
    cmp  = 1'b1;
    quot = QW'(42);
    ovf  = 1'b0;
    repeat (3) drive(1'b1, 1'b1, QW'(42), 1'b0);
    chk_zero("reset");
    // complete already high as reset releases
    job(QW'(42), 1'b0, 3, 35);
    job(QW'(3), 1'b0, 1, 35);
    job(QW'(27'h7FFFFFF), 1'b0, 2, 35);
    job(QW'(123), 1'b1, 1, 3);
    // held level then a second rise while busy
    job(QW'(999999), 1'b0, 5, 5);
    job(QW'(5), 1'b0, 1, 35);
    // reset at shift 10 of a running job
    drive(1'b0, 1'b1, QW'(12345), 1'b0);
    repeat (9) drive(1'b0, 1'b0, QW'($urandom), 1'b0);
    drive(1'b1, 1'b0, QW'(7), 1'b0);
    chk_zero("abort");
    job(QW'(0), 1'b0, 1, 35);
    repeat (40) begin
      rq = ($urandom_range(0, 1) == 0) ? QW'($urandom_range(0, 999))
                                       : QW'($urandom);
      job(rq, ($urandom_range(0, 5) == 0),
          $urandom_range(1, 6), $urandom_range(1, 40));
    end
    for (int i = 0; i < 60 && sb.size() != 0; i++)
      drive(1'b0, 1'b0, QW'($urandom), 1'b0);
    chk("drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
